// File: rtl/shift_reg_pkg.sv
// Shared types and sizing helpers for the duplex shift register.
// Defining SHIFT_REG_PARITY_EN appends an even-parity slot to every frame.
package shift_reg_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

`ifdef SHIFT_REG_PARITY_EN
    localparam int unsigned FRAME_EXTRA = 1;
`else
    localparam int unsigned FRAME_EXTRA = 0;
`endif

    function automatic int unsigned count_width(input int unsigned width);
        return $clog2(width + 2);
    endfunction

    function automatic int unsigned frame_len(input int unsigned width);
        return width + FRAME_EXTRA;
    endfunction

endpackage

// File: rtl/shift_bit_counter.sv
// Loadable down-counter for frame bit positions; flags the final slot.
// Saturates at zero, so an idle counter never wraps.
module shift_bit_counter #(
    parameter int unsigned CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          load,
    input  logic [CW-1:0] load_value,
    output logic          last
);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (enable) begin
            if (load) begin
                count <= load_value;
            end else if (count != '0) begin
                count <= count - CW'(1);
            end
        end
    end

    assign last = (count == CW'(1));

endmodule

// File: rtl/shift_register_duplex.sv
// Parametrised full-duplex shift register with IDLE/SHIFT framing FSM.
// Optional SHIFT_REG_PARITY_EN adds an even-parity slot and parity_err output.
module shift_register_duplex
    import shift_reg_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             wr_enable,
    input  logic [WIDTH-1:0] data_in,
    input  logic             serial_in,
    output logic             output_data,
    output logic [WIDTH-1:0] parallel_out,
    output logic             busy,
`ifdef SHIFT_REG_PARITY_EN
    output logic             parity_err,
`endif
    output logic             done
);

    localparam int unsigned FRAME_LEN = frame_len(WIDTH);
    localparam int unsigned CW        = count_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shifted;
    logic             tx_bit;
    logic             last_bit;

    shift_bit_counter #(.CW(CW)) u_counter (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load       (wr_enable),
        .load_value (CW'(FRAME_LEN)),
        .last       (last_bit)
    );

    // The received bit enters at the end that was just vacated by the transmitted bit.
    assign shifted = MSB_FIRST ? {shift_reg[WIDTH-2:0], serial_in}
                               : {serial_in, shift_reg[WIDTH-1:1]};
    assign tx_bit  = MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0];
    assign busy    = (state == SHIFT);

`ifdef SHIFT_REG_PARITY_EN
    logic tx_parity;
    assign output_data = (state == SHIFT) ? (last_bit ? tx_parity : tx_bit) : IDLE_LEVEL;
`else
    assign output_data = (state == SHIFT) ? tx_bit : IDLE_LEVEL;
`endif

    // NOTE: every register here is assigned with <= so all of them update from
    // the same pre-edge values; blocking = would leak new values into later lines.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            shift_reg    <= '0;
            parallel_out <= '0;
            done         <= 1'b0;
`ifdef SHIFT_REG_PARITY_EN
            tx_parity    <= 1'b0;
            parity_err   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (enable) begin
                if (wr_enable) begin
                    // A load in SHIFT aborts the frame: no done, parallel_out kept.
                    shift_reg <= data_in;
                    state     <= SHIFT;
`ifdef SHIFT_REG_PARITY_EN
                    tx_parity <= ^data_in;
`endif
                end else if (state == SHIFT) begin
                    if (last_bit) begin
                        state <= IDLE;
                        done  <= 1'b1;
`ifdef SHIFT_REG_PARITY_EN
                        // Parity slot: the data word is already complete, no shift.
                        parallel_out <= shift_reg;
                        parity_err   <= serial_in ^ (^shift_reg);
`else
                        shift_reg    <= shifted;
                        parallel_out <= shifted;
`endif
                    end else begin
                        shift_reg <= shifted;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_shift_register_duplex.sv
// Bench for shift_register_duplex: a hand table, corner sequences and random
// stimulus, with every cycle also checked against a bit-list frame model.
module tb_shift_register_duplex;

`ifdef SHIFT_REG_PARITY_EN
    localparam int FRAME = 9;
`else
    localparam int FRAME = 8;
`endif

    logic       clk = 1'b0;
    logic       reset, enable, wr_enable, lb, si0_drv, si1_drv;
    logic [7:0] data_in;
    logic       serial_in0, serial_in1, out0, out1, busy0, busy1, done0, done1;
    logic [7:0] pout0, pout1;
`ifdef SHIFT_REG_PARITY_EN
    logic       perr0, perr1;
`endif

    always #5 clk = ~clk;

    assign serial_in0 = lb ? out0 : si0_drv;
    assign serial_in1 = lb ? out1 : si1_drv;

    shift_register_duplex #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut0 (
        .clk(clk), .reset(reset), .enable(enable), .wr_enable(wr_enable),
        .data_in(data_in), .serial_in(serial_in0), .output_data(out0),
        .parallel_out(pout0), .busy(busy0),
`ifdef SHIFT_REG_PARITY_EN
        .parity_err(perr0),
`endif
        .done(done0)
    );

    shift_register_duplex #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .wr_enable(wr_enable),
        .data_in(data_in), .serial_in(serial_in1), .output_data(out1),
        .parallel_out(pout1), .busy(busy1),
`ifdef SHIFT_REG_PARITY_EN
        .parity_err(perr1),
`endif
        .done(done1)
    );

    // Frame model: a word to send, a slot index, and the list of bits received.
    typedef struct {
        logic       busy;
        int         idx;
        logic [7:0] data;
        logic [8:0] rx;
        logic       done;
        logic [7:0] pout;
        logic       err;
    } model_t;

    typedef struct {
        logic       rst, en, wr;
        logic [7:0] d;
        logic       o, b, dn;
        logic [7:0] p;
    } vec_t;

    model_t m0, m1;
    vec_t   tbl[16];
    int     n_vec = 0;
    int     total = 0;
    int     bad   = 0;

    function automatic logic model_out(input model_t m, input bit msb, input logic idle);
        if (!m.busy) return idle;
        if (m.idx >= 8) return ^m.data;
        return msb ? m.data[7 - m.idx] : m.data[m.idx];
    endfunction

    function automatic model_t model_step(input model_t m, input logic rst, input logic en,
                                          input logic wr, input logic [7:0] d,
                                          input logic si, input bit msb);
        model_t     n = m;
        logic [7:0] w;
        if (rst) begin
            n.busy = 1'b0; n.idx = 0; n.data = '0; n.rx = '0;
            n.done = 1'b0; n.pout = '0; n.err = 1'b0;
            return n;
        end
        n.done = 1'b0;
        if (!en) return n;
        if (wr) begin
            n.busy = 1'b1; n.idx = 0; n.data = d;
        end else if (m.busy) begin
            n.rx[m.idx] = si;
            n.idx = m.idx + 1;
            if (n.idx == FRAME) begin
                for (int i = 0; i < 8; i++) w[msb ? 7 - i : i] = n.rx[i];
                n.busy = 1'b0;
                n.done = 1'b1;
                n.pout = w;
                n.err  = n.rx[8] ^ (^w);
            end
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic compare_models();
        check("m0_out",  32'(out0),  32'(model_out(m0, 1'b1, 1'b0)));
        check("m0_busy", 32'(busy0), 32'(m0.busy));
        check("m0_done", 32'(done0), 32'(m0.done));
        check("m0_pout", 32'(pout0), 32'(m0.pout));
        check("m1_out",  32'(out1),  32'(model_out(m1, 1'b0, 1'b1)));
        check("m1_busy", 32'(busy1), 32'(m1.busy));
        check("m1_done", 32'(done1), 32'(m1.done));
        check("m1_pout", 32'(pout1), 32'(m1.pout));
`ifdef SHIFT_REG_PARITY_EN
        check("m0_perr", 32'(perr0), 32'(m0.err));
        check("m1_perr", 32'(perr1), 32'(m1.err));
`endif
    endtask

    // Drive one cycle of inputs, advance through the edge, compare at negedge.
    task automatic tick(input logic rst, input logic en, input logic wr, input logic [7:0] d,
                        input logic l, input logic s0, input logic s1);
        logic si0m, si1m;
        reset = rst; enable = en; wr_enable = wr; data_in = d;
        lb = l; si0_drv = s0; si1_drv = s1;
        si0m = l ? model_out(m0, 1'b1, 1'b0) : s0;
        si1m = l ? model_out(m1, 1'b0, 1'b1) : s1;
        @(posedge clk);
        m0 = model_step(m0, rst, en, wr, d, si0m, 1'b1);
        m1 = model_step(m1, rst, en, wr, d, si1m, 1'b0);
        @(negedge clk);
        compare_models();
    endtask

    task automatic add(input logic rst, input logic en, input logic wr, input logic [7:0] d,
                       input logic o, input logic b, input logic dn, input logic [7:0] p);
        tbl[n_vec] = '{rst: rst, en: en, wr: wr, d: d, o: o, b: b, dn: dn, p: p};
        n_vec++;
    endtask

    initial begin
        logic [7:0] pat;
        logic [7:0] got;
        logic       any_done;
        int         cnt;
        bit         seen;

        reset = 1'b1; enable = 1'b0; wr_enable = 1'b0; data_in = '0;
        lb = 1'b0; si0_drv = 1'b0; si1_drv = 1'b0;
        m0 = model_step(m0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        m1 = model_step(m1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Loopback frame 8'h2A on the MSB-first instance, expected values by hand.
        pat = 8'h2A;
        add(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
        add(1'b0, 1'b1, 1'b1, 8'h2A, 1'b0, 1'b1, 1'b0, 8'h00);
        for (int b = 6; b >= 0; b--) add(1'b0, 1'b1, 1'b0, 8'h00, pat[b], 1'b1, 1'b0, 8'h00);
`ifdef SHIFT_REG_PARITY_EN
        add(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00);
`endif
        add(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h2A);
        add(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h2A);
        for (int i = 0; i < n_vec; i++) begin
            tick(tbl[i].rst, tbl[i].en, tbl[i].wr, tbl[i].d, 1'b1, 1'b0, 1'b0);
            check($sformatf("tbl%0d_out", i),  32'(out0),  32'(tbl[i].o));
            check($sformatf("tbl%0d_busy", i), 32'(busy0), 32'(tbl[i].b));
            check($sformatf("tbl%0d_done", i), 32'(done0), 32'(tbl[i].dn));
            check($sformatf("tbl%0d_pout", i), 32'(pout0), 32'(tbl[i].p));
        end
`ifdef SHIFT_REG_PARITY_EN
        check("loop_parity_ok", 32'(perr0), 32'd0);
`endif

        // LSB-first instance, 8'hA5 with serial_in held at 1.
        tick(1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1);
        got[0] = out1;
        for (int i = 1; i < 8; i++) begin
            tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            got[i] = out1;
        end
        check("lsb_bits", 32'(got), 32'h0000_00A5);
        if (FRAME == 9) tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("lsb_done", 32'(done1), 32'd1);
        check("lsb_pout", 32'(pout1), 32'h0000_00FF);

        // Enable low for three cycles while bit 2 of 8'hF0 is on the line.
        tick(1'b0, 1'b1, 1'b1, 8'hF0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("stall_bit2", 32'(out0), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            check("stall_hold", 32'(out0), 32'd1);
        end
        cnt = 0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            cnt++;
            if (done0 === 1'b1) seen = 1'b1;
        end
        check("stall_done_seen", 32'(seen), 32'd1);
        check("stall_done_at", 32'(cnt), 32'(FRAME - 2));
        check("stall_pout", 32'(pout0), 32'h0000_00F0);

        // Reload with 8'hFF at bit 4 of an 8'h2A frame.
        any_done = 1'b0;
        tick(1'b0, 1'b1, 1'b1, 8'h2A, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            any_done |= done0;
        end
        tick(1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        any_done |= done0;
        cnt = (out0 === 1'b1) ? 1 : 0;
        for (int i = 1; i < 8; i++) begin
            tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            any_done |= done0;
            if (out0 === 1'b1) cnt++;
        end
        check("abort_no_done", 32'(any_done), 32'd0);
        check("abort_ones", 32'(cnt), 32'd8);
        check("abort_pout_kept", 32'(pout0), 32'h0000_00F0);
        if (FRAME == 9) tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("abort_done", 32'(done0), 32'd1);
        check("abort_pout", 32'(pout0), 32'h0000_00FF);

        // Load request on the completion edge: reload wins, no done.
        tick(1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < FRAME - 1; i++) tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        check("lastwr_done", 32'(done0), 32'd0);
        check("lastwr_busy", 32'(busy0), 32'd1);
        check("lastwr_pout", 32'(pout0), 32'h0000_00FF);
        for (int i = 0; i < FRAME + 1; i++) tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Reset at bit 5 of a frame.
        tick(1'b0, 1'b1, 1'b1, 8'h2A, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("rst_out0", 32'(out0), 32'd0);
        check("rst_out1", 32'(out1), 32'd1);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_pout", 32'(pout0), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            tick(1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 11) == 0), 8'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_register_duplex.md
Name: shift_register_duplex

Overview:
- Parametrised successor to the 8-bit parallel-in/serial-out shift register.
- Adds configurable width, shift direction and idle line level.
- Captures a serial input into the vacated end of the register, so one frame transmits and receives at the same time.
- A framing FSM with busy/done handshake marks frame boundaries. Used as the serial front end for the accumulator processor's I/O path.

Parameters:
- WIDTH, 8, frame width in bits (>=2).
- MSB_FIRST, 1, 1 = shift out data_in[WIDTH-1] first; 0 = LSB first.
- IDLE_LEVEL, 1'b0, value driven on output_data while not shifting.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  clock enable; when low all state holds.
- wr_enable  in  1  parallel load request (sampled only when enable=1).
- data_in  in  WIDTH  parallel word to transmit.
- serial_in  in  1  receive bit, sampled on each shift edge.
- output_data  out  1  serial transmit bit.
- parallel_out  out  WIDTH  last fully received word (registered).
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse when a frame completes.

Behaviour:
- Clock and reset:
  - Single clock clk.
  - reset is synchronous and active-high and overrides everything, including enable.
  - Reset values: state=IDLE, shift reg=0, bit count=0, parallel_out=0, done=0, busy=0, output_data=IDLE_LEVEL.
- FSM states: IDLE, SHIFT.
- IDLE:
  - On an edge with enable & wr_enable: shift reg<=data_in, count<=WIDTH, go to SHIFT.
  - Otherwise hold.
- SHIFT, on each edge with enable=1:
  - MSB_FIRST=1: reg<={reg[WIDTH-2:0],serial_in}. MSB_FIRST=0: reg<={serial_in,reg[WIDTH-1:1]}.
  - count<=count-1.
- Completion: on the edge where count==1 and enable=1:
  - Perform the final shift.
  - parallel_out<=post-shift reg; done<=1 for exactly one cycle; go to IDLE.
- output_data (combinational from state/reg):
  - In SHIFT: reg[WIDTH-1] (MSB_FIRST=1) or reg[0] (MSB_FIRST=0).
  - In IDLE: IDLE_LEVEL.
  - First frame bit appears the cycle after the load edge; each bit is held exactly one enabled cycle.
- busy equals (state==SHIFT).
- Latency: load edge to done high = WIDTH enabled cycles plus 1 edge.
- enable low mid-frame: reg, count, output_data and parallel_out all frozen. done, if high, still deasserts on the next edge.
- wr_enable in SHIFT (with enable): aborts the current frame and reloads data_in with count=WIDTH. No done pulse; parallel_out unchanged.
- wr_enable on the completion edge: the reload wins. No done pulse and parallel_out is not updated (abort rule).
- reset mid-frame: frame discarded, all outputs return to reset values on that edge.
- Count register width: $clog2(WIDTH+2) bits, unsigned. It never wraps below 0.

Optional Feature:
- Macro: SHIFT_REG_PARITY_EN.
- When defined:
  - Frame length becomes WIDTH+1.
  - After the WIDTH data bits, output_data carries an even parity bit (^data_in captured at load) for one enabled cycle.
  - The serial_in bit received in that slot is compared against even parity of the received word; mismatch sets output port parity_err (1 bit, registered).
  - parity_err updates together with done and resets to 0.
  - done asserts after the parity slot.
- When not defined: no parity slot, no parity_err port, frame length WIDTH.

Decomposition:
- Shared package shift_reg_pkg:
  - state enum {IDLE, SHIFT}.
  - Function computing the count width from WIDTH.
  - Localparam for frame length (WIDTH or WIDTH+1 under the macro).
- One natural sub-module: shift_bit_counter.
  - Loadable down-counter with enable.
  - Provides a last-bit flag (count==1).
  - Instantiated by the FSM.

Test Plan:
- WIDTH=8, MSB_FIRST=1, load 8'b00101010 with enable=1, serial_in tied to output_data (loopback) -> output_data=0,0,1,0,1,0,1,0 on the 8 cycles after load; done pulses once; parallel_out=8'h2A; busy high 8 cycles.
- MSB_FIRST=0, load 8'hA5, serial_in=1 constant -> output_data=1,0,1,0,0,1,0,1; parallel_out=8'hFF at done.
- Frame of 8'hF0 with enable low for 3 cycles after bit 2 -> output_data holds bit 2 for 4 cycles total; done arrives 3 cycles late; received word unchanged.
- Load 8'h2A, assert wr_enable with data_in=8'hFF at bit 4 -> no done; new frame emits eight 1s; parallel_out updates only at the second frame end.
- reset asserted at bit 5 -> next cycle output_data=IDLE_LEVEL, busy=0, done=0, parallel_out=0.
- SHIFT_REG_PARITY_EN, load 8'b00101010 (three ones), loopback -> 9th bit=1, parity_err=0. Force the 9th serial_in bit to 0 -> parity_err=1.
